// File: rtl/fetch_unit_if.sv
// Byte-serial instruction memory port between the fetch stage and imem.
interface fetch_unit_if;
    logic        req;
    logic [63:0] addr;
    logic        ack;
    logic [7:0]  rdata;
    logic        err;

    modport master (output req, output addr, input ack, input rdata, input err);
    modport slave  (input req, input addr, output ack, output rdata, output err);
endinterface

// File: rtl/fetch_unit.sv
// Y86-64 fetch stage: picks the PC, reads the instruction one byte at a time
// over the imem handshake, splits it into fields and predicts the next PC.
//
// state  | meaning
// START  | latch selected PC, clear byte counter
// BYTE   | request bytes at PC+cnt until the instruction is complete
// HOLD   | f_* valid and stable until decode takes them
// HALTED | non-AOK instruction delivered; only a redirect restarts fetch
module fetch_unit #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                F_stall_i,
    input  logic [3:0]          M_icode_i,
    input  logic                M_cnd_i,
    input  logic [63:0]         M_valA_i,
    input  logic [3:0]          W_icode_i,
    input  logic [63:0]         W_valM_i,
    fetch_unit_if.master        imem,
    output logic [3:0]          f_icode_o,
    output logic [3:0]          f_ifun_o,
    output logic [3:0]          f_rA_o,
    output logic [3:0]          f_rB_o,
    output logic [63:0]         f_valC_o,
    output logic [63:0]         f_valP_o,
    output logic [63:0]         f_predPC_o,
    output logic [2:0]          f_stat_o,
    output logic                f_valid_o
);
    typedef enum logic [1:0] {ST_START, ST_BYTE, ST_HOLD, ST_HALTED} state_t;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam int WAIT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(ACK_TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [63:0]       pc_q, pc_d, pred_pc_q, pred_pc_d;
    logic [3:0]        cnt_q, cnt_d, len_q, len_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [3:0]        f_icode_q, f_icode_d, f_ifun_q, f_ifun_d;
    logic [3:0]        f_ra_q, f_ra_d, f_rb_q, f_rb_d;
    logic [63:0]       f_valc_q, f_valc_d, f_valp_q, f_valp_d, f_predpc_q, f_predpc_d;
    logic [2:0]        f_stat_q, f_stat_d;
    logic              f_valid_q, f_valid_d;

    logic              redir_valid;
    logic [63:0]       redir_pc, sel_pc;
    logic [3:0]        icode_cur, len_cur, valc_base;
    logic [2:0]        valc_idx;
    logic [63:0]       valc_cur, valp_cur, pred_cur;
    logic [2:0]        stat_cur;
    logic              last_byte;

    function automatic logic [3:0] len_of(input logic [3:0] icode);
        case (icode)
            4'h2, 4'h6, 4'hA, 4'hB: len_of = 4'd2;
            4'h7, 4'h8:             len_of = 4'd9;
            4'h3, 4'h4, 4'h5:       len_of = 4'd10;
            default:                len_of = 4'd1;
        endcase
    endfunction

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_START;
            pc_q       <= '0;
            pred_pc_q  <= '0;
            cnt_q      <= '0;
            len_q      <= 4'd1;
            wait_q     <= WAIT_LOAD;
            f_icode_q  <= 4'h1;
            f_ifun_q   <= 4'h0;
            f_ra_q     <= 4'hF;
            f_rb_q     <= 4'hF;
            f_valc_q   <= '0;
            f_valp_q   <= '0;
            f_predpc_q <= '0;
            f_stat_q   <= STAT_AOK;
            f_valid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pred_pc_q  <= pred_pc_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            wait_q     <= wait_d;
            f_icode_q  <= f_icode_d;
            f_ifun_q   <= f_ifun_d;
            f_ra_q     <= f_ra_d;
            f_rb_q     <= f_rb_d;
            f_valc_q   <= f_valc_d;
            f_valp_q   <= f_valp_d;
            f_predpc_q <= f_predpc_d;
            f_stat_q   <= f_stat_d;
            f_valid_q  <= f_valid_d;
        end
    end

    // Redirect from a mispredicted jXX wins over a ret target
    always_comb begin
        redir_valid = 1'b0;
        redir_pc    = '0;
        if (M_icode_i == 4'h7 && !M_cnd_i) begin
            redir_valid = 1'b1;
            redir_pc    = M_valA_i;
        end else if (W_icode_i == 4'h9) begin
            redir_valid = 1'b1;
            redir_pc    = W_valM_i;
        end
        sel_pc = redir_valid ? redir_pc : pred_pc_q;
    end

    // Fold the byte on the bus into the instruction being assembled
    always_comb begin
        icode_cur = (cnt_q == 4'd0) ? imem.rdata[7:4] : f_icode_q;
        len_cur   = (cnt_q == 4'd0) ? len_of(imem.rdata[7:4]) : len_q;
        valc_base = (len_cur == 4'd10) ? 4'd2 : 4'd1;
        valc_idx  = 3'(cnt_q - valc_base);
        valc_cur  = (cnt_q == 4'd0) ? 64'd0 : f_valc_q;
        if (len_cur >= 4'd9 && cnt_q >= valc_base)
            valc_cur[{valc_idx, 3'b000} +: 8] = imem.rdata;
        valp_cur  = pc_q + 64'(len_cur);
        last_byte = (cnt_q + 4'd1) == len_cur;
        pred_cur  = (icode_cur == 4'h7 || icode_cur == 4'h8) ? valc_cur : valp_cur;
        if (icode_cur == 4'h0)
            stat_cur = STAT_HLT;
        else if (icode_cur > 4'hB)
            stat_cur = STAT_INS;
        else
            stat_cur = STAT_AOK;
    end

    // Next-state and datapath update
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pred_pc_d  = pred_pc_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        wait_d     = wait_q;
        f_icode_d  = f_icode_q;
        f_ifun_d   = f_ifun_q;
        f_ra_d     = f_ra_q;
        f_rb_d     = f_rb_q;
        f_valc_d   = f_valc_q;
        f_valp_d   = f_valp_q;
        f_predpc_d = f_predpc_q;
        f_stat_d   = f_stat_q;
        f_valid_d  = f_valid_q;
        case (state_q)
            ST_START: begin
                pc_d      = sel_pc;
                cnt_d     = '0;
                wait_d    = WAIT_LOAD;
                f_valid_d = 1'b0;
                state_d   = ST_BYTE;
            end
            ST_BYTE: begin
                if (redir_valid) begin
                    // aborted fetch restarts from the redirect target
                    pred_pc_d = redir_pc;
                    f_valid_d = 1'b0;
                    state_d   = ST_START;
                end else if ((imem.ack && imem.err) || (!imem.ack && wait_q == '0)) begin
                    f_icode_d = 4'h1;
                    f_ifun_d  = 4'h0;
                    f_stat_d  = STAT_ADR;
                    f_valid_d = 1'b1;
                    state_d   = ST_HOLD;
                end else if (imem.ack) begin
                    if (cnt_q == 4'd0) begin
                        f_icode_d = imem.rdata[7:4];
                        f_ifun_d  = imem.rdata[3:0];
                        f_ra_d    = 4'hF;
                        f_rb_d    = 4'hF;
                        len_d     = len_cur;
                    end
                    if (cnt_q == 4'd1 && (len_cur == 4'd2 || len_cur == 4'd10)) begin
                        f_ra_d = imem.rdata[7:4];
                        f_rb_d = imem.rdata[3:0];
                    end
                    f_valc_d = valc_cur;
                    cnt_d    = cnt_q + 4'd1;
                    wait_d   = WAIT_LOAD;
                    if (last_byte) begin
                        f_valp_d   = valp_cur;
                        pred_pc_d  = pred_cur;
                        f_predpc_d = pred_cur;
                        f_stat_d   = stat_cur;
                        f_valid_d  = 1'b1;
                        state_d    = ST_HOLD;
                    end
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            ST_HOLD: begin
                if (redir_valid) begin
                    pred_pc_d = redir_pc;
                    f_valid_d = 1'b0;
                    state_d   = ST_START;
                end else if (!F_stall_i) begin
                    f_valid_d = 1'b0;
                    state_d   = (f_stat_q == STAT_AOK) ? ST_START : ST_HALTED;
                end
            end
            ST_HALTED: begin
                f_valid_d = 1'b0;
                if (redir_valid) begin
                    pred_pc_d = redir_pc;
                    state_d   = ST_START;
                end
            end
            default: state_d = ST_START;
        endcase
    end

    // Bus and fetched-field outputs
    always_comb begin
        imem.req   = (state_q == ST_BYTE);
        imem.addr  = pc_q + 64'(cnt_q);
        f_icode_o  = f_icode_q;
        f_ifun_o   = f_ifun_q;
        f_rA_o     = f_ra_q;
        f_rB_o     = f_rb_q;
        f_valC_o   = f_valc_q;
        f_valP_o   = f_valp_q;
        f_predPC_o = f_predpc_q;
        f_stat_o   = f_stat_q;
        f_valid_o  = f_valid_q;
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios followed by a random program
// with random memory wait states and decode stalls, checked against a
// byte-level reference decoder.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        F_stall_i;
    logic [3:0]  M_icode_i;
    logic        M_cnd_i;
    logic [63:0] M_valA_i;
    logic [3:0]  W_icode_i;
    logic [63:0] W_valM_i;
    logic [3:0]  f_icode_o, f_ifun_o, f_rA_o, f_rB_o;
    logic [63:0] f_valC_o, f_valP_o, f_predPC_o;
    logic [2:0]  f_stat_o;
    logic        f_valid_o;

    fetch_unit_if bus();

    fetch_unit #(.ACK_TIMEOUT(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .F_stall_i  (F_stall_i),
        .M_icode_i  (M_icode_i),
        .M_cnd_i    (M_cnd_i),
        .M_valA_i   (M_valA_i),
        .W_icode_i  (W_icode_i),
        .W_valM_i   (W_valM_i),
        .imem       (bus),
        .f_icode_o  (f_icode_o),
        .f_ifun_o   (f_ifun_o),
        .f_rA_o     (f_rA_o),
        .f_rB_o     (f_rB_o),
        .f_valC_o   (f_valC_o),
        .f_valP_o   (f_valP_o),
        .f_predPC_o (f_predPC_o),
        .f_stat_o   (f_stat_o),
        .f_valid_o  (f_valid_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
        logic [63:0] pred;
        logic [2:0]  stat;
    } exp_t;

    logic [7:0]  mem [0:511];
    int          total = 0;
    int          bad = 0;
    int          wait_max = 0;
    int          wcnt = 0;
    bit          stuck = 1'b0;
    bit          err_en = 1'b0;
    logic [63:0] err_addr = '0;

    function automatic logic [7:0] rd(input logic [63:0] a);
        return mem[a[8:0]];
    endfunction

    task automatic wr(input logic [63:0] a, input logic [7:0] d);
        mem[a[8:0]] = d;
    endtask

    // Reference decoder: instruction = icode:ifun [, rA:rB] [, 8-byte constant]
    function automatic exp_t ref_fetch(input logic [63:0] pc);
        exp_t       e;
        logic [7:0] b0, b1;
        bit         regs, cons;
        int         len;
        b0 = rd(pc);
        e.icode = b0[7:4];
        e.ifun  = b0[3:0];
        regs = e.icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
        cons = e.icode inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8};
        len  = 1 + (regs ? 1 : 0) + (cons ? 8 : 0);
        e.ra = 4'hF;
        e.rb = 4'hF;
        if (regs) begin
            b1 = rd(pc + 64'd1);
            e.ra = b1[7:4];
            e.rb = b1[3:0];
        end
        e.valc = '0;
        if (cons)
            for (int i = 0; i < 8; i++)
                e.valc = e.valc | (64'(rd(pc + 64'(1 + (regs ? 1 : 0) + i))) << (8 * i));
        e.valp = pc + 64'(len);
        e.pred = (e.icode == 4'h7 || e.icode == 4'h8) ? e.valc : e.valp;
        if (e.icode == 4'h0)      e.stat = 3'd2;
        else if (e.icode > 4'hB)  e.stat = 3'd4;
        else                      e.stat = 3'd1;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_f(input string tag, input exp_t e);
        chk({tag, ".icode"},  f_icode_o,  e.icode);
        chk({tag, ".ifun"},   f_ifun_o,   e.ifun);
        chk({tag, ".rA"},     f_rA_o,     e.ra);
        chk({tag, ".rB"},     f_rB_o,     e.rb);
        chk({tag, ".valC"},   f_valC_o,   e.valc);
        chk({tag, ".valP"},   f_valP_o,   e.valp);
        chk({tag, ".predPC"}, f_predPC_o, e.pred);
        chk({tag, ".stat"},   f_stat_o,   e.stat);
    endtask

    // Wait (bounded) for a request, then check it and its address
    task automatic wait_req(input string tag, input logic [63:0] exp_addr);
        int n = 0;
        while (!bus.req && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".req"},  bus.req,  1'b1);
        chk({tag, ".addr"}, bus.addr, exp_addr);
    endtask

    // Wait (bounded) for f_valid, counting request and accepted-byte cycles
    task automatic wait_valid_cnt(input string tag, output int acks, output int reqs);
        int n = 0;
        acks = 0;
        reqs = 0;
        while (!f_valid_o && n < 100) begin
            if (bus.req) reqs++;
            if (bus.req && bus.ack) acks++;
            @(negedge clk);
            n++;
        end
        chk({tag, ".valid"}, f_valid_o, 1'b1);
    endtask

    task automatic redirect_w(input logic [63:0] target);
        W_icode_i = 4'h9;
        W_valM_i  = target;
        @(negedge clk);
        W_icode_i = 4'h0;
    endtask

    // Memory model: answers after a random number of wait cycles
    task automatic responder();
        forever begin
            @(posedge clk);
            #1;
            if (bus.req && !stuck) begin
                if (wcnt == 0) begin
                    bus.ack   = 1'b1;
                    bus.rdata = rd(bus.addr);
                    bus.err   = err_en && (bus.addr == err_addr);
                    wcnt      = int'($urandom_range(0, wait_max));
                end else begin
                    bus.ack = 1'b0;
                    bus.err = 1'b0;
                    wcnt--;
                end
            end else begin
                bus.ack = 1'b0;
                bus.err = 1'b0;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t        e;
        int          n, acks, reqs;
        logic [63:0] pc, vc;
        logic [63:0] prog[$];
        logic [3:0]  ic;
        bit          regs, cons;
        int          off;
        string       tag;

        rst = 1'b1; F_stall_i = 1'b0;
        M_icode_i = 4'h0; M_cnd_i = 1'b1; M_valA_i = '0;
        W_icode_i = 4'h0; W_valM_i = '0;
        bus.ack = 1'b0; bus.rdata = '0; bus.err = 1'b0;
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        mem[0] = 8'h10;
        fork
            responder();
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.valid", f_valid_o, 1'b0);
        chk("rst.req", bus.req, 1'b0);
        e = '{4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0, 64'd0, 3'd1};
        check_f("rst", e);
        rst = 1'b0;

        // nop, zero-wait memory
        wait_req("nop", 64'h0);
        wait_valid_cnt("nop", acks, reqs);
        e = '{4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd1, 64'd1, 3'd1};
        check_f("nop", e);
        wait_req("nop_next", 64'h1);

        // directed program image; reset lands in the middle of a fetch
        {mem[0], mem[1], mem[2], mem[3], mem[4]} = {8'h30, 8'hF3, 8'hEF, 8'hCD, 8'hAB};
        {mem[5], mem[6], mem[7], mem[8], mem[9]} = {8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
        mem[10] = 8'h70; mem[11] = 8'h20;
        mem[32] = 8'h70; mem[33] = 8'h00; mem[34] = 8'h01;
        mem[256] = 8'h60; mem[257] = 8'h12;
        {mem[258], mem[259], mem[260], mem[261], mem[262]} = {8'h30, 8'hF4, 8'h11, 8'h22, 8'h33};
        {mem[263], mem[264], mem[265], mem[266], mem[267]} = {8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        mem[64] = 8'hC0; mem[80] = 8'h10; mem[112] = 8'h00; mem[128] = 8'h10;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst.req", bus.req, 1'b0);
        chk("midrst.valid", f_valid_o, 1'b0);
        rst = 1'b0;

        wait_req("irmovq", 64'h0);
        wait_valid_cnt("irmovq", acks, reqs);
        chk("irmovq.acks", 64'(acks), 64'd10);
        e = '{4'h3, 4'h0, 4'hF, 4'h3, 64'h0123456789ABCDEF, 64'd10, 64'd10, 3'd1};
        check_f("irmovq", e);

        wait_req("jmp1", 64'h0A);
        wait_valid_cnt("jmp1", acks, reqs);
        e = '{4'h7, 4'h0, 4'hF, 4'hF, 64'h20, 64'h13, 64'h20, 3'd1};
        check_f("jmp1", e);

        wait_req("jmp2", 64'h20);
        wait_valid_cnt("jmp2", acks, reqs);
        e = '{4'h7, 4'h0, 4'hF, 4'hF, 64'h100, 64'h29, 64'h100, 3'd1};
        check_f("jmp2", e);

        // addq held by decode stall for three cycles
        wait_req("addq", 64'h100);
        wait_valid_cnt("addq", acks, reqs);
        e = '{4'h6, 4'h0, 4'h1, 4'h2, 64'd0, 64'h102, 64'h102, 3'd1};
        check_f("addq", e);
        F_stall_i = 1'b1;
        n = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.req) n++;
        end
        chk("stall.req_cycles", 64'(n), 64'd0);
        chk("stall.valid", f_valid_o, 1'b1);
        check_f("stall", e);
        F_stall_i = 1'b0;

        // mispredict during byte 4 of an irmovq
        wait_req("abort", 64'h102);
        acks = 0;
        n = 0;
        while (n < 50) begin
            if (bus.req && bus.ack) acks++;
            if (acks == 3) break;
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        M_icode_i = 4'h7; M_cnd_i = 1'b0; M_valA_i = 64'h40;
        @(negedge clk);
        M_icode_i = 4'h0; M_cnd_i = 1'b1;
        chk("abort.valid", f_valid_o, 1'b0);
        chk("abort.req", bus.req, 1'b0);

        // invalid instruction: valid for one cycle, then halted
        wait_req("ins", 64'h40);
        wait_valid_cnt("ins", acks, reqs);
        chk("ins.stat", f_stat_o, 3'd4);
        chk("ins.icode", f_icode_o, 4'hC);
        @(negedge clk);
        chk("ins.valid_drop", f_valid_o, 1'b0);
        n = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.req) n++;
        end
        chk("halted.req_cycles", 64'(n), 64'd0);

        // memory error on ack
        err_en = 1'b1; err_addr = 64'h50;
        redirect_w(64'h50);
        wait_req("err", 64'h50);
        wait_valid_cnt("err", acks, reqs);
        chk("err.stat", f_stat_o, 3'd3);
        chk("err.icode", f_icode_o, 4'h1);
        @(negedge clk);
        chk("err.valid_drop", f_valid_o, 1'b0);
        err_en = 1'b0;

        // ack never arrives
        stuck = 1'b1;
        redirect_w(64'h60);
        wait_req("tmo", 64'h60);
        wait_valid_cnt("tmo", acks, reqs);
        chk("tmo.req_cycles", 64'(reqs), 64'd16);
        chk("tmo.stat", f_stat_o, 3'd3);
        chk("tmo.icode", f_icode_o, 4'h1);
        stuck = 1'b0;

        // halt instruction
        redirect_w(64'h70);
        wait_req("hlt", 64'h70);
        wait_valid_cnt("hlt", acks, reqs);
        e = '{4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'h71, 64'h71, 3'd2};
        check_f("hlt", e);
        @(negedge clk);
        chk("hlt.valid_drop", f_valid_o, 1'b0);

        // mispredict has priority over ret
        M_icode_i = 4'h7; M_cnd_i = 1'b0; M_valA_i = 64'h80;
        W_icode_i = 4'h9; W_valM_i = 64'h90;
        @(negedge clk);
        M_icode_i = 4'h0; M_cnd_i = 1'b1; W_icode_i = 4'h0;
        wait_req("prio", 64'h80);

        // random program, random wait states and stalls
        for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
        pc = '0;
        prog.delete();
        while (pc < 64'h1C0 && prog.size() < 40) begin
            ic = 4'($urandom_range(1, 11));
            regs = ic inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
            cons = ic inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8};
            wr(pc, {ic, 4'($urandom_range(0, 6))});
            off = 1;
            if (regs) begin
                wr(pc + 64'd1, 8'($urandom));
                off = 2;
            end
            if (cons) begin
                if (ic == 4'h7 || ic == 4'h8)
                    vc = pc + 64'(off + 8) + 64'($urandom_range(0, 6));
                else
                    vc = {$urandom, $urandom};
                for (int k = 0; k < 8; k++) wr(pc + 64'(off + k), vc[8*k +: 8]);
            end
            prog.push_back(pc);
            e = ref_fetch(pc);
            pc = e.pred;
        end
        wait_max = 3;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        foreach (prog[i]) begin
            tag = $sformatf("rnd%0d", i);
            e = ref_fetch(prog[i]);
            wait_req(tag, prog[i]);
            wait_valid_cnt(tag, acks, reqs);
            check_f(tag, e);
            n = int'($urandom_range(0, 2));
            if (n > 0) begin
                F_stall_i = 1'b1;
                repeat (n) @(negedge clk);
                check_f({tag, "_stall"}, e);
                F_stall_i = 1'b0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
